// File: rtl/quartet_program_loader_if.sv
// MMIO host-channel bundle between the program loader and the quartet host interface.
interface quartet_program_loader_if #(
  parameter int MMIO_DATA_WIDTH  = 32,
  parameter int MMIO_INDEX_WIDTH = 32
);
  logic                        mmio_write_req;
  logic [MMIO_INDEX_WIDTH-1:0] mmio_write_index;
  logic [MMIO_DATA_WIDTH-1:0]  mmio_write_data;
  logic                        mmio_write_ack;
  logic                        mmio_read_req;
  logic [MMIO_INDEX_WIDTH-1:0] mmio_read_index;

  modport master (
    output mmio_write_req, mmio_write_index, mmio_write_data,
    output mmio_read_req, mmio_read_index,
    input  mmio_write_ack
  );

  modport slave (
    input  mmio_write_req, mmio_write_index, mmio_write_data,
    input  mmio_read_req, mmio_read_index,
    output mmio_write_ack
  );
endinterface

// File: rtl/quartet_program_loader.sv
// Boot sequencer: resets/enables a quartet, streams core and router words over MMIO, runs it to halt.
// Optional halt watchdog enabled by defining TIA_LOADER_WATCHDOG_EN.
module quartet_program_loader #(
  parameter int MMIO_DATA_WIDTH   = 32,
  parameter int MMIO_INDEX_WIDTH  = 32,
  parameter int NUM_PES           = 4,
  parameter int NUM_CORE_WORDS    = 40,
  parameter int NUM_ROUTER_WORDS  = 8,
  parameter int PE_STRIDE         = 256,
  parameter int CORE_BASE_INDEX   = 0,
  parameter int ROUTER_BASE_INDEX = 128,
  parameter int IMAGE_INDEX_WIDTH = 9,
  parameter int TIMEOUT_CYCLES    = 100000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [31:0]                  run_cycles,
  output logic                         quartet_reset,
  output logic                         quartet_enable,
  output logic                         quartet_execute,
  input  logic                         quartet_halted,
  output logic [IMAGE_INDEX_WIDTH-1:0] image_read_index,
  input  logic [MMIO_DATA_WIDTH-1:0]   image_read_data,
  quartet_program_loader_if.master     mmio
);

`ifdef TIA_LOADER_WATCHDOG_EN
  localparam bit WATCHDOG_ON = 1'b1;
`else
  localparam bit WATCHDOG_ON = 1'b0;
`endif

  localparam int MAX_WORDS = (NUM_CORE_WORDS > NUM_ROUTER_WORDS) ? NUM_CORE_WORDS : NUM_ROUTER_WORDS;
  localparam int JW        = (MAX_WORDS < 2) ? 1 : $clog2(MAX_WORDS);
  localparam int PW        = (NUM_PES < 2) ? 1 : $clog2(NUM_PES);
  localparam int TOTAL     = NUM_PES * (NUM_CORE_WORDS + NUM_ROUTER_WORDS);

  localparam logic [31:0] LAST_CORE     = 32'(NUM_CORE_WORDS) - 32'd1;
  localparam logic [31:0] LAST_ROUTER   = 32'(NUM_ROUTER_WORDS) - 32'd1;
  localparam logic [31:0] LAST_PE       = 32'(NUM_PES) - 32'd1;
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic        START_PHASE   = (NUM_CORE_WORDS == 0);
  localparam logic        HAS_ROUTER    = (NUM_ROUTER_WORDS != 0);

  localparam logic [MMIO_INDEX_WIDTH-1:0] STRIDE      = MMIO_INDEX_WIDTH'(PE_STRIDE);
  localparam logic [MMIO_INDEX_WIDTH-1:0] CORE_BASE   = MMIO_INDEX_WIDTH'(CORE_BASE_INDEX);
  localparam logic [MMIO_INDEX_WIDTH-1:0] ROUTER_BASE = MMIO_INDEX_WIDTH'(ROUTER_BASE_INDEX);

  typedef enum logic [3:0] {
    IDLE, RSTQ, ENQ, FETCH, WAITD, WRITE, RUN, DONE, ERROR
  } state_t;

  state_t                        state;
  logic                          phase;
  logic [PW-1:0]                 pe;
  logic [JW-1:0]                 j;
  logic [MMIO_INDEX_WIDTH-1:0]   next_index;
  logic [31:0]                   last_j;
  logic [31:0]                   cycles_next;

  assign mmio.mmio_read_req   = 1'b0;
  assign mmio.mmio_read_index = '0;

  // image_read_index doubles as the linear word counter k: the image is laid out in load order
  always_comb begin
    next_index  = STRIDE * MMIO_INDEX_WIDTH'(pe) + (phase ? ROUTER_BASE : CORE_BASE)
                + MMIO_INDEX_WIDTH'(j);
    last_j      = phase ? LAST_ROUTER : LAST_CORE;
    cycles_next = (run_cycles == '1) ? run_cycles : run_cycles + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                 <= IDLE;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      error                 <= 1'b0;
      run_cycles            <= '0;
      quartet_reset         <= 1'b0;
      quartet_enable        <= 1'b0;
      quartet_execute       <= 1'b0;
      image_read_index      <= '0;
      phase                 <= 1'b0;
      pe                    <= '0;
      j                     <= '0;
      mmio.mmio_write_req   <= 1'b0;
      mmio.mmio_write_index <= '0;
      mmio.mmio_write_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            done             <= 1'b0;
            error            <= 1'b0;
            run_cycles       <= '0;
            image_read_index <= '0;
            phase            <= START_PHASE;
            pe               <= '0;
            j                <= '0;
            busy             <= 1'b1;
            quartet_reset    <= 1'b1;
            quartet_execute  <= 1'b0;
            state            <= RSTQ;
          end
        end
        RSTQ: begin
          quartet_reset  <= 1'b0;
          quartet_enable <= 1'b1;
          state          <= ENQ;
        end
        ENQ: begin
          if (TOTAL == 0) begin
            quartet_execute <= 1'b1;
            state           <= RUN;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: state <= WAITD;
        WAITD: begin
          mmio.mmio_write_data  <= image_read_data;
          mmio.mmio_write_index <= next_index;
          mmio.mmio_write_req   <= 1'b1;
          state                 <= WRITE;
        end
        WRITE: begin
          if (mmio.mmio_write_ack) begin
            mmio.mmio_write_req <= 1'b0;
            image_read_index    <= image_read_index + 1'b1;
            state               <= FETCH;
            if (32'(j) == last_j) begin
              j <= '0;
              if (32'(pe) == LAST_PE) begin
                pe <= '0;
                if (!phase && HAS_ROUTER) begin
                  phase <= 1'b1;
                end else begin
                  quartet_execute <= 1'b1;
                  state           <= RUN;
                end
              end else begin
                pe <= pe + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        RUN: begin
          run_cycles <= cycles_next;
          // Halt wins over a watchdog expiry landing on the same cycle
          if (quartet_halted) begin
            quartet_execute <= 1'b0;
            done            <= 1'b1;
            busy            <= 1'b0;
            state           <= DONE;
          end else if (WATCHDOG_ON && (cycles_next == TIMEOUT_LIMIT)) begin
            quartet_execute <= 1'b0;
            error           <= 1'b1;
            busy            <= 1'b0;
            state           <= ERROR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/quartet_program_loader.md
Name: quartet_program_loader

Overview:
- Hardware replacement for host-side bring-up of a quartet. On start, it resets the quartet and enables it, then streams a program image into the quartet over the MMIO write channel.
- The image holds the core register-file and instruction words for 4 PEs, followed by the router setting words.
- After loading, it asserts execute, waits for halted, and reports the run length. It sits between a boot ROM/SRAM and the quartet host interface.

Parameters:
- MMIO_DATA_WIDTH, 32, MMIO data width.
- MMIO_INDEX_WIDTH, 32, MMIO index width.
- NUM_PES, 4, PEs per quartet.
- NUM_CORE_WORDS, 40, register-file plus instruction-memory words per PE.
- NUM_ROUTER_WORDS, 8, router setting words per PE; 0 skips the router phase.
- PE_STRIDE, 256, MMIO address-space words per PE.
- CORE_BASE_INDEX, 0, per-PE offset of the register file.
- ROUTER_BASE_INDEX, 128, per-PE offset of the router settings.
- IMAGE_INDEX_WIDTH, 9, image memory address width.
- TIMEOUT_CYCLES, 100000, halt watchdog limit (optional feature only).

Ports:
- clock, in, 1, sole clock.
- reset, in, 1, synchronous, active-low.
- start, in, 1, one-cycle request; sampled only in IDLE.
- busy, out, 1, high in every state except IDLE, DONE and ERROR.
- done, out, 1, level; high from halt until the next accepted start.
- error, out, 1, level; watchdog expiry (optional feature only).
- run_cycles, out, 32, cycles spent in RUN; saturates at 0xFFFFFFFF.
- quartet_reset, out, 1, active-high reset to the quartet.
- quartet_enable, out, 1, quartet enable.
- quartet_execute, out, 1, quartet execute.
- quartet_halted, in, 1, quartet halted.
- image_read_index, out, IMAGE_INDEX_WIDTH, image memory address.
- image_read_data, in, MMIO_DATA_WIDTH, image memory data; synchronous read, 1-cycle latency.
- mmio_write_req, out, 1, MMIO write request.
- mmio_write_index, out, MMIO_INDEX_WIDTH, MMIO write address.
- mmio_write_data, out, MMIO_DATA_WIDTH, MMIO write data.
- mmio_write_ack, in, 1, MMIO write acknowledge.
- mmio_read_req, out, 1, tied 0.
- mmio_read_index, out, MMIO_INDEX_WIDTH, tied 0.

Behaviour:
- Reset (reset==0 at a posedge):
  - State goes to IDLE.
  - All outputs go to 0, including run_cycles and all counters.
  - This applies mid-operation: an in-flight mmio_write_req drops on the next cycle and the quartet is not signalled further.
- Image layout: word k = pe*NUM_CORE_WORDS + j for the core phase. Router phase words follow at NUM_PES*NUM_CORE_WORDS + pe*NUM_ROUTER_WORDS + j.
- MMIO index:
  - Core phase: PE_STRIDE*pe + CORE_BASE_INDEX + j.
  - Router phase: PE_STRIDE*pe + ROUTER_BASE_INDEX + j.
  - Computed at MMIO_INDEX_WIDTH; wraps modulo 2^MMIO_INDEX_WIDTH.
- States and transitions:
  - IDLE: on start, clear done, error, run_cycles and counters, then go to RSTQ. DONE and ERROR also accept start and behave like IDLE.
  - RSTQ: quartet_reset=1 for exactly 1 cycle, quartet_execute=0, then go to ENQ.
  - ENQ: quartet_enable goes 1 and stays 1 until reset; go to FETCH.
  - FETCH: drive image_read_index = k for 1 cycle, then go to WAITD.
  - WAITD: capture image_read_data into the data register, then go to WRITE.
  - WRITE:
    - mmio_write_req=1 with index and data held stable until mmio_write_ack==1 is sampled.
    - The next cycle req=0. Then advance j, then pe, then phase, and return to FETCH.
    - After the last word go to RUN.
  - Ack handling: req is never asserted in the cycle after an ack. An ack already high on entry to WRITE completes that word in 1 cycle.
  - Per-word cost: 3 cycles + ack wait.
  - Phase skipping: if NUM_ROUTER_WORDS==0, the router phase is skipped. If NUM_CORE_WORDS==0, the core phase is skipped.
  - RUN:
    - quartet_execute=1 and run_cycles increments each cycle.
    - On quartet_halted==1: execute=0 and done=1 in the next cycle, then go to DONE.
    - A halted that is already high on entry ends RUN after 1 counted cycle.
  - DONE: hold done=1. quartet_enable stays 1.
- start is ignored while busy.

Optional Feature:
- Macro: TIA_LOADER_WATCHDOG_EN.
- Defined: a counter runs in RUN. When run_cycles reaches TIMEOUT_CYCLES without halt:
  - execute drops and error=1, with done=0;
  - state goes to ERROR, which holds until start or reset.
- Undefined: error is tied 0 and RUN waits indefinitely.

Test Plan:
- Zero-wait ack, defaults (4*40+4*8=192 words), image word w = 0xA5000000|w:
  - expect 192 writes in ascending order;
  - PE2 core word 5 lands at index 517 with data 0xA5000055;
  - PE3 router word 7 lands at index 903 with data 0xA50000BF;
  - RUN entered 1+1+192*3 cycles after start acceptance.
- Ack delayed 4 cycles per write: req and index/data stay stable until ack, req is low the cycle after ack, total load is 192*7 cycles.
- halted raised 50 cycles into RUN: execute falls next cycle, done=1, run_cycles=50. A second start clears done and run_cycles and repeats the sequence.
- reset low during word 37's WRITE: all outputs 0 the next cycle, no further MMIO writes. A subsequent start restarts at word 0 with a quartet_reset pulse.
- start pulsed during load: ignored, with no restart and an unchanged write sequence.
- With TIA_LOADER_WATCHDOG_EN and TIMEOUT_CYCLES=20, halted held low: error=1 after 20 RUN cycles, execute=0, done=0, run_cycles=20.
